// File: rtl/dmem_if.sv
// Request/response bundle for one data-memory requester (processor or external port).
// Handshake: the requester raises req_val with a stable payload and holds both until a
// cycle where req_rdy is also high; that cycle is the transfer. resp_val pulses for one
// cycle carrying read data and cannot be back-pressured.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_val;
    logic              req_rdy;
    logic              req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_val;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_val, req_type, req_addr, req_wdata,
        input  req_rdy, resp_val, resp_rdata
    );

    modport slave (
        input  req_val, req_type, req_addr, req_wdata,
        output req_rdy, resp_val, resp_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one never-stalling data-memory port between the pipeline (p) and the external
// port (e); p has priority except when e has been refused STARVE_MAX cycles in a row.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_if.slave             p,
    dmem_if.slave             e,
    output logic              mem_req_val,
    output logic              mem_req_type,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [CNT_W-1:0]  dbg_starve_cnt,
    output logic              dbg_resp_pend,
    output logic              dbg_resp_owner
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             resp_pend, resp_pend_nxt;
    logic             resp_owner, resp_owner_nxt;
    logic             grant_p, grant_e;

    // Grant and memory-side mux. With STARVE_MAX = 0 the counter never leaves 0, so e
    // always takes priority.
    always_comb begin
        grant_e       = !rst && e.req_val && (!p.req_val || (starve_cnt == CNT_MAX));
        grant_p       = !rst && p.req_val && !grant_e;
        p.req_rdy     = grant_p;
        e.req_rdy     = grant_e;
        mem_req_val   = 1'b0;
        mem_req_type  = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (grant_e) begin
            mem_req_val   = 1'b1;
            mem_req_type  = e.req_type;
            mem_req_addr  = e.req_addr;
            mem_req_wdata = e.req_wdata;
        end else if (grant_p) begin
            mem_req_val   = 1'b1;
            mem_req_type  = p.req_type;
            mem_req_addr  = p.req_addr;
            mem_req_wdata = p.req_wdata;
        end
    end

    always_comb begin
        starve_nxt     = starve_cnt;
        resp_pend_nxt  = mem_req_val && !mem_req_type;
        resp_owner_nxt = grant_e;
        if (!e.req_val || grant_e) begin
            starve_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            resp_pend  <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            resp_pend  <= resp_pend_nxt;
            resp_owner <= resp_owner_nxt;
        end
    end

    // Read data is steered to the requester that issued the read one cycle earlier.
    always_comb begin
        p.resp_val   = 1'b0;
        p.resp_rdata = '0;
        e.resp_val   = 1'b0;
        e.resp_rdata = '0;
        if (resp_pend && !rst) begin
            if (resp_owner) begin
                e.resp_val   = 1'b1;
                e.resp_rdata = mem_resp_rdata;
            end else begin
                p.resp_val   = 1'b1;
                p.resp_rdata = mem_resp_rdata;
            end
        end
    end

    assign dbg_starve_cnt = starve_cnt;
    assign dbg_resp_pend  = resp_pend;
    assign dbg_resp_owner = resp_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter: a reference model predicts grants and read
// responses into a queue that a separate monitor drains when the DUT responds.
module tb_dmem_arbiter;

    localparam int SMAX  = 4;
    localparam int EXP_W = 65;  // {cycle[31:0], owner, data[31:0]}

    typedef struct packed {
        logic        val;
        logic        typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT with STARVE_MAX = 4 ----------------
    dmem_if #(.ADDR_W(32), .DATA_W(32)) p_bus ();
    dmem_if #(.ADDR_W(32), .DATA_W(32)) e_bus ();
    logic        mem_req_val, mem_req_type;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [2:0]  dbg_cnt;
    logic        dbg_pend, dbg_owner;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst), .p(p_bus.slave), .e(e_bus.slave),
        .mem_req_val(mem_req_val), .mem_req_type(mem_req_type),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_rdata(mem_resp_rdata),
        .dbg_starve_cnt(dbg_cnt), .dbg_resp_pend(dbg_pend), .dbg_resp_owner(dbg_owner)
    );

    // ---------------- DUT with STARVE_MAX = 0 ----------------
    dmem_if #(.ADDR_W(32), .DATA_W(32)) p0_bus ();
    dmem_if #(.ADDR_W(32), .DATA_W(32)) e0_bus ();
    logic        mem0_req_val, mem0_req_type;
    logic [31:0] mem0_req_addr, mem0_req_wdata, mem0_resp_rdata;
    logic [0:0]  dbg0_cnt;
    logic        dbg0_pend, dbg0_owner;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) u_dut0 (
        .clk(clk), .rst(rst), .p(p0_bus.slave), .e(e0_bus.slave),
        .mem_req_val(mem0_req_val), .mem_req_type(mem0_req_type),
        .mem_req_addr(mem0_req_addr), .mem_req_wdata(mem0_req_wdata),
        .mem_resp_rdata(mem0_resp_rdata),
        .dbg_starve_cnt(dbg0_cnt), .dbg_resp_pend(dbg0_pend), .dbg_resp_owner(dbg0_owner)
    );

    // ---------------- scoreboard counters ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- memory behind the DUTs ----------------
    logic [31:0] mem_arr [logic [31:0]];
    always @(posedge clk) begin
        if (mem_req_val && mem_req_type) mem_arr[mem_req_addr] = mem_req_wdata;
        if (mem_req_val && !mem_req_type)
            mem_resp_rdata <= mem_arr.exists(mem_req_addr) ? mem_arr[mem_req_addr]
                                                           : init_word(mem_req_addr);
        else
            mem_resp_rdata <= $urandom;
        mem0_resp_rdata <= $urandom;
    end

    // ---------------- reference model ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      model_mem [logic [31:0]];
    int               m_wait = 0;   // consecutive cycles E has been refused
    logic             m_gp, m_ge;
    req_t             m_rq;
    int               cap_idx = 10;
    logic [9:0]       e_win, p_win;

    always @(negedge clk) begin
        if (rst) begin
            m_wait = 0;
        end else begin
            m_ge = e_bus.req_val && (!p_bus.req_val || m_wait == SMAX);
            m_gp = p_bus.req_val && !m_ge;
            m_rq = '0;
            if (m_ge) m_rq = '{1'b1, e_bus.req_type, e_bus.req_addr, e_bus.req_wdata};
            else if (m_gp) m_rq = '{1'b1, p_bus.req_type, p_bus.req_addr, p_bus.req_wdata};
            check("p_rdy", 32'(p_bus.req_rdy), 32'(m_gp));
            check("e_rdy", 32'(e_bus.req_rdy), 32'(m_ge));
            check("starve_cnt", 32'(dbg_cnt), 32'(m_wait));
            check("mem_val", 32'(mem_req_val), 32'(m_rq.val));
            check("mem_type", 32'(mem_req_type), 32'(m_rq.typ));
            check("mem_addr", mem_req_addr, m_rq.addr);
            check("mem_wdata", mem_req_wdata, m_rq.wdata);
            if (m_rq.val && !m_rq.typ)
                exp_q.push_back({32'(cyc), m_ge,
                                 model_mem.exists(m_rq.addr) ? model_mem[m_rq.addr]
                                                             : init_word(m_rq.addr)});
            if (m_rq.val && m_rq.typ) model_mem[m_rq.addr] = m_rq.wdata;
            if (!e_bus.req_val || m_ge) m_wait = 0;
            else if (m_wait < SMAX) m_wait++;
            if (cap_idx < 10) begin
                e_win[cap_idx] = e_bus.req_rdy;
                p_win[cap_idx] = p_bus.req_rdy;
                cap_idx++;
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [EXP_W-1:0] mon_ent;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("rst_p_rdy", 32'(p_bus.req_rdy), 32'd0);
            check("rst_e_rdy", 32'(e_bus.req_rdy), 32'd0);
            check("rst_mem_val", 32'(mem_req_val), 32'd0);
            check("rst_p_resp", 32'(p_bus.resp_val), 32'd0);
            check("rst_e_resp", 32'(e_bus.resp_val), 32'd0);
            check("rst_starve_cnt", 32'(dbg_cnt), 32'd0);
        end else if (exp_q.size() != 0 && exp_q[0][64:33] == 32'(cyc - 1)) begin
            mon_ent = exp_q.pop_front();
            if (mon_ent[32]) begin
                check("e_resp_val", 32'(e_bus.resp_val), 32'd1);
                check("e_resp_data", e_bus.resp_rdata, mon_ent[31:0]);
                check("p_resp_quiet", {31'd0, p_bus.resp_val} | p_bus.resp_rdata, 32'd0);
            end else begin
                check("p_resp_val", 32'(p_bus.resp_val), 32'd1);
                check("p_resp_data", p_bus.resp_rdata, mon_ent[31:0]);
                check("e_resp_quiet", {31'd0, e_bus.resp_val} | e_bus.resp_rdata, 32'd0);
            end
        end else begin
            check("no_p_resp", {31'd0, p_bus.resp_val} | p_bus.resp_rdata, 32'd0);
            check("no_e_resp", {31'd0, e_bus.resp_val} | e_bus.resp_rdata, 32'd0);
        end
    end

    // ---------------- STARVE_MAX = 0 checker: E always wins ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("s0_e_rdy", 32'(e0_bus.req_rdy), 32'(e0_bus.req_val));
            check("s0_p_rdy", 32'(p0_bus.req_rdy), 32'(p0_bus.req_val && !e0_bus.req_val));
            check("s0_mem_val", 32'(mem0_req_val), 32'(p0_bus.req_val || e0_bus.req_val));
            check("s0_mem_addr", mem0_req_addr,
                  e0_bus.req_val ? e0_bus.req_addr : (p0_bus.req_val ? p0_bus.req_addr : 32'd0));
            check("s0_starve_cnt", 32'(dbg0_cnt), 32'd0);
        end
    end

    // ---------------- driver ----------------
    req_t p_script[$];
    req_t e_script[$];
    req_t p_cur = '0;
    req_t e_cur = '0;

    function automatic req_t mk(input logic v, input logic t, input logic [31:0] a,
                                input logic [31:0] d);
        return '{v, t, a, d};
    endfunction

    function automatic req_t rand_req(input int busy_pct);
        return '{($urandom_range(0, 99) < busy_pct), ($urandom_range(0, 2) == 0),
                 32'($urandom_range(0, 15)) << 2, $urandom};
    endfunction

    task automatic apply();
        p_bus.req_val = p_cur.val; p_bus.req_type = p_cur.typ;
        p_bus.req_addr = p_cur.addr; p_bus.req_wdata = p_cur.wdata;
        e_bus.req_val = e_cur.val; e_bus.req_type = e_cur.typ;
        e_bus.req_addr = e_cur.addr; e_bus.req_wdata = e_cur.wdata;
    endtask

    task automatic idle(input int n);
        p_cur = '0; e_cur = '0; apply();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Plays both scripts; a valid item is held until granted, an idle item lasts one cycle.
    task automatic run_scripts(input int max_cyc);
        int n = 0;
        while ((p_script.size() != 0 || e_script.size() != 0 || p_cur.val || e_cur.val)
               && n < max_cyc) begin
            if (!p_cur.val) p_cur = (p_script.size() != 0) ? p_script.pop_front() : '0;
            if (!e_cur.val) e_cur = (e_script.size() != 0) ? e_script.pop_front() : '0;
            apply();
            @(negedge clk);
            if (p_cur.val && p_bus.req_rdy) p_cur.val = 1'b0;
            if (e_cur.val && e_bus.req_rdy) e_cur.val = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("run_done", 32'(n < max_cyc), 32'd1);
        idle(3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        p_cur = '0; e_cur = '0; apply();
        p0_bus.req_val = 0; p0_bus.req_type = 0; p0_bus.req_addr = 0; p0_bus.req_wdata = 0;
        e0_bus.req_val = 0; e0_bus.req_type = 0; e0_bus.req_addr = 0; e0_bus.req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_starve_cnt", 32'(dbg_cnt), 32'd0);
        check("reset_resp_pend", 32'(dbg_pend), 32'd0);
        check("reset_resp_owner", 32'(dbg_owner), 32'd0);
        @(posedge clk); #1;

        // lone P read
        p_script.push_back(mk(1, 0, 32'h100, 0));
        run_scripts(20);

        // both contend for 10 cycles: P x4, E, P x4, E
        repeat (10) p_script.push_back(mk(1, 0, 32'h200, 0));
        e_script.push_back(mk(1, 0, 32'h300, 0));
        e_script.push_back(mk(1, 0, 32'h304, 0));
        cap_idx = 0;
        run_scripts(40);
        check("contend_e_wins", 32'(e_win), 32'(10'b10_0001_0000));
        check("contend_p_wins", 32'(p_win), 32'(10'b01_1110_1111));

        // alternating back-to-back reads P, E, P
        p_script.push_back(mk(1, 0, 32'h10, 0));
        p_script.push_back(mk(0, 0, 0, 0));
        p_script.push_back(mk(1, 0, 32'h30, 0));
        e_script.push_back(mk(0, 0, 0, 0));
        e_script.push_back(mk(1, 0, 32'h20, 0));
        run_scripts(20);

        // E write then P read of the same word
        e_script.push_back(mk(1, 1, 32'h40, 32'hDEAD_BEEF));
        p_script.push_back(mk(0, 0, 0, 0));
        p_script.push_back(mk(1, 0, 32'h40, 0));
        run_scripts(20);

        // reset the cycle after a granted P read while E is being starved
        p_cur = mk(1, 0, 32'h80, 0); e_cur = mk(1, 0, 32'h90, 0); apply();
        @(posedge clk); #1;
        p_cur = mk(1, 0, 32'h84, 0); apply();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        p_cur = '0; e_cur = '0; apply();
        rst = 1'b0;
        idle(3);

        // randomized traffic, P busier so E starvation is exercised
        for (int i = 0; i < 300; i++) begin
            p_script.push_back(rand_req(85));
            e_script.push_back(rand_req(50));
        end
        run_scripts(3000);

        // STARVE_MAX = 0 instance under random contention
        for (int i = 0; i < 60; i++) begin
            p0_bus.req_val = ($urandom_range(0, 3) != 0);
            p0_bus.req_type = 1'($urandom_range(0, 1));
            p0_bus.req_addr = $urandom; p0_bus.req_wdata = $urandom;
            e0_bus.req_val = ($urandom_range(0, 1) != 0);
            e0_bus.req_type = 1'($urandom_range(0, 1));
            e0_bus.req_addr = $urandom; e0_bus.req_wdata = $urandom;
            @(posedge clk); #1;
        end
        p0_bus.req_val = 0; e0_bus.req_val = 0;
        idle(3);

        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
